// File: rtl/req_collector.sv
// Request collection stage: latches rising edges on eight request lines as pending,
// arbitrates among them and offers one grant at a time downstream under valid/ready.
module req_collector #(
  parameter bit RR_EN        = 1'b1,
  parameter bit CLR_ON_GRANT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       gnt_ready,
  input  logic       clr_ovf,
  output logic       gnt_valid,
  output logic [7:0] gnt_onehot,
  output logic [2:0] gnt_idx,
  output logic [7:0] pending,
  output logic       ovf
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state;
  logic [7:0] req_q;
  logic [2:0] ptr;
  logic [7:0] req_edge;
  logic [7:0] cand;
  logic [7:0] load_mask;
  logic [7:0] clr_mask;
  logic [2:0] base;
  logic [2:0] sel_idx;
  logic       sel_found;
  logic       handshake;
  logic       do_load;

  // The bit being retired is excluded and the scan starts just past it, so a
  // back-to-back reload behaves exactly as if the pointer had already moved.
  always_comb begin
    handshake = (state == OFFER) && gnt_valid && gnt_ready;
    req_edge  = req_in & ~req_q;
    cand      = handshake ? (pending & ~gnt_onehot) : pending;
    if (RR_EN)
      base = handshake ? (gnt_idx + 3'd1) : ptr;
    else
      base = 3'd0;
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (cand[base + 3'(k)]) begin
        sel_found = 1'b1;
        sel_idx   = base + 3'(k);
      end
    end
    do_load   = sel_found && ((state == IDLE) || handshake);
    load_mask = do_load ? (8'd1 << sel_idx) : 8'd0;
    if (CLR_ON_GRANT)
      clr_mask = load_mask;
    else
      clr_mask = handshake ? gnt_onehot : 8'd0;
  end

  // A fresh edge always beats a coincident clear; ovf only flags edges that
  // land on a bit that really stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 8'hFF;
      pending <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      req_q   <= req_in;
      pending <= (pending & ~clr_mask) | req_edge;
      if (|(req_edge & pending & ~clr_mask))
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= 8'h00;
      gnt_idx    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (do_load) begin
            gnt_onehot <= load_mask;
            gnt_idx    <= sel_idx;
            gnt_valid  <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (handshake) begin
            ptr <= gnt_idx + 3'd1;
            if (do_load) begin
              gnt_onehot <= load_mask;
              gnt_idx    <= sel_idx;
            end else begin
              gnt_valid  <= 1'b0;
              gnt_onehot <= 8'h00;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/req_collector.md
Name: req_collector

Overview:
- Upstream request-collection stage for the 8-to-3 encoder.
- Detects rising edges on 8 request lines and latches them as pending.
- Selects one pending request at a time by round-robin.
- Presents the grant downstream as a one-hot vector (the encoder's input format) plus its 3-bit index, under a valid/ready handshake.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration from the rotating pointer; 0 = fixed priority, bit 0 highest.
- CLR_ON_GRANT, 1: 1 = pending bit clears when the request is loaded into the grant register; 0 = pending bit clears on handshake.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- req_in  input  8  level request lines, synchronous to clk
- gnt_ready  input  1  downstream accepts the current grant
- clr_ovf  input  1  clears the sticky overflow flag
- gnt_valid  output  1  grant outputs hold a valid request
- gnt_onehot  output  8  one-hot grant, feeds the downstream encoder input
- gnt_idx  output  3  binary index of the granted bit
- pending  output  8  current pending register
- ovf  output  1  sticky flag: an edge arrived on an already-pending bit

Behaviour:
- Reset (async, rst_n=0):
  - gnt_valid=0, gnt_onehot=0, gnt_idx=0, pending=0, ovf=0.
  - RR pointer=0, state=IDLE.
  - Previous-request register req_q=8'hFF, so lines already high at reset release do not fire.
  - Asserting reset mid-offer drops the grant immediately; no handshake completes.
- Edge detect:
  - edge = req_in & ~req_q; req_q <= req_in every cycle.
  - pending[i] is set at the clock edge that samples edge[i].
- Overflow:
  - If edge[i]=1 while pending[i]=1 at that edge, the request is lost and ovf is set.
  - ovf stays set until a cycle with clr_ovf=1.
  - If a set event and clr_ovf coincide, the set wins.
- Selection:
  - RR_EN=1: first set bit of pending, scanning upward from ptr and wrapping 7->0.
  - RR_EN=0: lowest set bit of pending.
  - Selection uses the registered pending value only, never the same-cycle edge.
- FSM, two states:
  - IDLE: if pending!=0, load gnt_onehot/gnt_idx with the selected bit, set gnt_valid=1, go to OFFER. Otherwise stay.
  - OFFER: gnt_onehot, gnt_idx and gnt_valid are held stable while gnt_ready=0.
  - On gnt_valid&gnt_ready: ptr <= gnt_idx+1 (mod 8, 7 wraps to 0).
  - After the handshake, if pending (excluding the bit being retired) is nonzero, load the next grant in the same cycle and stay in OFFER, giving back-to-back throughput of 1 grant/cycle. Otherwise clear gnt_valid and gnt_onehot, leave gnt_idx unchanged, and go to IDLE.
- Pending clear:
  - CLR_ON_GRANT=1: bit clears at the load edge.
  - CLR_ON_GRANT=0: bit clears at the handshake edge.
  - If a new edge on the same bit coincides with its clear, the set wins: pending stays 1, no ovf.
- Latency: req_in rises before edge E0 -> pending set at E0 -> gnt_valid=1 after E1 (2 cycles). With gnt_ready held high, the grant retires at E2.
- Invariants:
  - gnt_onehot is always zero or exactly one bit.
  - gnt_onehot == (1<<gnt_idx) whenever gnt_valid=1.
  - gnt_onehot=0 whenever gnt_valid=0.

Test Plan:
1. Reset with req_in=8'hFF held through release -> no pending, gnt_valid stays 0 for 10 cycles. Then drop to 0 and raise bit 3 -> gnt_onehot=8'h08, gnt_idx=3 two cycles after the rise.
2. Round-robin: raise req_in=8'h81 in one cycle, gnt_ready=1 -> grants idx 0 then idx 7 on consecutive cycles. Repeat the pulse -> order is 0 then 7 again (ptr wrapped to 0 after 7). With RR_EN=0 -> always 0 then 7.
3. Backpressure: pending=8'h24, gnt_ready=0 for 5 cycles -> gnt_idx=2 and gnt_onehot=8'h04 held stable. Assert ready one cycle -> next grant idx 5 the following cycle.
4. Overflow: pulse bit 6 twice while gnt_ready=0 and bit 6 still pending -> ovf=1. Pulse clr_ovf -> ovf=0 next cycle. Pulse clr_ovf with a simultaneous overflow event -> ovf=1.
5. Set/clear collision (CLR_ON_GRANT=1): a new edge on bit 1 in the same cycle bit 1 is loaded -> pending[1]=1 afterwards, ovf=0, and a second grant idx 1 follows.
6. Mid-offer reset: gnt_valid=1, idx 4, rst_n pulsed low asynchronously between clock edges -> all outputs zero immediately. No grant is issued after release unless a fresh edge occurs.
